seg7_scan_driver: RTL

Parametrised time-multiplexed driver for a common-anode 7-segment display bank of `DIGITS` digits. It takes packed hex nibbles plus per-digit decimal point, blank and flash controls. It scans one digit at a time with a configurable dwell time and a dead-band guard, and blinks flashing digits at a frame-derived rate. It sits between the game/score logic and the board display pins, replacing per-digit static decode instances.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_scan_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment scan driver:
//   SEG_GLYPH : 16-entry active-low glyph table, {a,b,c,d,e,f,g} with a at
//               the MSB, entry n is SEG_GLYPH[n]. Lowercase b and d are used.
//   SEG_OFF   : all segments (and the decimal point) dark.
//   hexWidth  : packed hex-bus width for a given digit count.
// ---------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Listed from F down to 0 so that index n of the packed array is glyph n.
   localparam logic [15:0][6:0] SEG_GLYPH = {
      7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
      7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
   };

   function automatic int hexWidth(input int digits);
      return 4 * digits;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to active-low segment pattern lookup.
// Ports:
//   i_nibble : hex value 0..F
//   o_seg    : active-low {a,b,c,d,e,f,g}, a at the MSB
// ---------------------------------------------------------------------------
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   // Straight table lookup; the table already holds active-low patterns.
   assign o_seg = SEG_GLYPH[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a common-anode 7-segment bank. One digit is
// lit at a time for SCAN_DIV cycles, the first GUARD cycles of every slot
// keep all anodes off to avoid ghosting. Inputs are snapshotted once per
// frame so a frame always shows one consistent set of values.
//
// Optional feature macro: SEG7_BLINK_EN
//   defined   : frame counter, blink phase and flash gating are built.
//   undefined : i_flash is ignored and flashing digits stay lit.
//
// Ports:
//   i_clk        : system clock
//   i_rst        : synchronous active-high reset
//   i_hex        : packed nibbles, digit k is i_hex[4k+3:4k]
//   i_point      : decimal point enable per digit
//   i_blank      : force digit dark
//   i_flash      : make digit blink
//   o_an         : anode selects, active-low, one low or all high
//   o_seg        : active-low {a,b,c,d,e,f,g,p}, a at the MSB
//   o_frame_tick : high in the cycle the inputs are snapshotted
// ---------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 1,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [hexWidth(DIGITS)-1:0]  i_hex,
   input  logic [DIGITS-1:0]            i_point,
   input  logic [DIGITS-1:0]            i_blank,
   input  logic [DIGITS-1:0]            i_flash,
   output logic [DIGITS-1:0]            o_an,
   output logic [7:0]                   o_seg,
   output logic                         o_frame_tick
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]            r_cnt;
   logic [IDX_W-1:0]            r_idx;
   logic [hexWidth(DIGITS)-1:0] r_shHex;
   logic [DIGITS-1:0]           r_shPoint;
   logic [DIGITS-1:0]           r_shBlank;
   logic [DIGITS-1:0]           r_an;
   logic [7:0]                  r_seg;

   logic                        w_snap;
   logic [3:0]                  w_nibble;
   logic                        w_point;
   logic                        w_blank;
   logic                        w_dark;
   logic [6:0]                  w_glyph;
   logic [DIGITS-1:0]           w_anNext;
   logic [7:0]                  w_segNext;

`ifdef SEG7_BLINK_EN
   localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES);

   logic [DIGITS-1:0]           r_shFlash;
   logic [FRM_W-1:0]            r_frameCnt;
   logic                        r_phase;
   logic                        w_flash;
`else
   logic                        w_unusedFlash;
   assign w_unusedFlash = ^i_flash;
`endif

   // The start of slot 0 is the frame boundary; reset holds it off so the
   // tick only shows once the scan is actually running.
   assign w_snap       = (r_cnt == '0) && (r_idx == '0);
   assign o_frame_tick = w_snap & ~i_rst;

   // Pick the shadowed controls of the digit currently being scanned.
   always_comb begin
      w_nibble = 4'h0;
      w_point  = 1'b0;
      w_blank  = 1'b1;
`ifdef SEG7_BLINK_EN
      w_flash  = 1'b0;
`endif
      for (int k = 0; k < DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nibble = r_shHex[4*k +: 4];
            w_point  = r_shPoint[k];
            w_blank  = r_shBlank[k];
`ifdef SEG7_BLINK_EN
            w_flash  = r_shFlash[k];
`endif
         end
      end
   end

   seg7_decode u_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_glyph)
   );

`ifdef SEG7_BLINK_EN
   assign w_dark = w_blank | (w_flash & ~r_phase);
`else
   assign w_dark = w_blank;
`endif

   // Next pin values: dark during the guard band, otherwise select the
   // current anode and show the glyph unless the digit is forced dark.
   always_comb begin
      w_anNext  = '1;
      w_segNext = SEG_OFF;
      if (r_cnt >= CNT_GUARD) begin
         w_anNext = ~(DIGITS'(1) << r_idx);
         if (!w_dark) begin
            w_segNext = {w_glyph, ~w_point};
         end
      end
   end

   // Scan position, input snapshot and the registered pins. Pins are
   // registered so the display sees clean edges one cycle after the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shHex   <= '0;
         r_shPoint <= '0;
         r_shBlank <= '1;
         r_an      <= '1;
         r_seg     <= SEG_OFF;
      end else begin
         if (w_snap) begin
            r_shHex   <= i_hex;
            r_shPoint <= i_point;
            r_shBlank <= i_blank;
         end
         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_an  <= w_anNext;
         r_seg <= w_segNext;
      end
   end

`ifdef SEG7_BLINK_EN
   // Blink timing. r_frameCnt holds how many frames have been shown in the
   // current phase; when a new frame starts after BLINK_FRAMES of them, the
   // phase flips and that new frame is the first of the new phase, so the
   // flipped phase covers the whole snapshot frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shFlash  <= '0;
         r_frameCnt <= '0;
         r_phase    <= 1'b1;
      end else if (w_snap) begin
         r_shFlash <= i_flash;
         if (r_frameCnt == FRM_LAST) begin
            r_frameCnt <= FRM_W'(1);
            r_phase    <= ~r_phase;
         end else begin
            r_frameCnt <= r_frameCnt + 1'b1;
         end
      end
   end
`endif

   assign o_an  = r_an;
   assign o_seg = r_seg;

endmodule
